// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch resolver and the IF-stage BTB.
package branch_pkg;

  localparam int unsigned BTB_XLEN    = 32;
  localparam int unsigned SHADOW_W    = 4;
  localparam int unsigned ILEN_STEP_C = 2;
  localparam int unsigned ILEN_STEP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SHADOW   = 2'd2
  } resolver_state_e;

  typedef struct packed {
    logic                valid;
    logic                taken;
    logic [BTB_XLEN-1:0] pc;
    logic [BTB_XLEN-1:0] target;
  } btb_update_t;

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: BTB update, front-end redirect and the wrong-path flush shadow.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_valid,
  input  logic [XLEN-1:0]      i_pc,
  input  logic                 i_is_branch,
  input  logic                 i_is_jump,
  input  logic                 i_is_compressed,
  input  logic                 i_actual_taken,
  input  logic [XLEN-1:0]      i_actual_target,
  input  logic                 i_pred_taken,
  input  logic [XLEN-1:0]      i_pred_target,
  output logic                 o_update,
  output logic [XLEN-1:0]      o_update_pc,
  output logic [XLEN-1:0]      o_update_target,
  output logic                 o_update_taken,
  output logic                 o_redirect,
  output logic [XLEN-1:0]      o_redirect_pc,
  output logic                 o_flush,
  output logic [CNT_WIDTH-1:0] o_resolved_count,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);

  resolver_state_e     state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  btb_update_t         upd_q, upd_d;
  logic                redirect_q, redirect_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic                flush_q, flush_d;

  logic            accept, ctrl, eff_taken, mispredict;
  logic [XLEN-1:0] seq_pc, correct_pc;

  // Resolution of the instruction currently in EX.
  always_comb begin
    ctrl       = i_is_branch | i_is_jump;
    eff_taken  = i_is_jump | (i_is_branch & i_actual_taken);
    seq_pc     = i_pc + (i_is_compressed ? XLEN'(ILEN_STEP_C) : XLEN'(ILEN_STEP_W));
    correct_pc = eff_taken ? i_actual_target : seq_pc;
    accept     = i_valid && !i_stall && (state_q == ST_IDLE);
    mispredict = ctrl ? ((eff_taken != i_pred_taken) ||
                         (eff_taken && i_pred_taken && (i_actual_target != i_pred_target)))
                      : i_pred_taken;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    upd_d         = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && mispredict) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_d  = ST_SHADOW;
        shadow_d = SHADOW_W'(FLUSH_CYCLES);
      end
      ST_SHADOW: begin
        if (!i_stall) begin
          if (shadow_q <= SHADOW_W'(1)) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
          end else begin
            shadow_d = shadow_q - SHADOW_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Non-control hits on a stale BTB entry get a not-taken update so the entry decays.
    if (accept && (ctrl || i_pred_taken)) begin
      upd_d.valid  = 1'b1;
      upd_d.taken  = eff_taken;
      upd_d.pc     = BTB_XLEN'(i_pc);
      upd_d.target = BTB_XLEN'(ctrl ? i_actual_target : seq_pc);
    end
    if (accept && mispredict) begin
      redirect_d    = 1'b1;
      redirect_pc_d = correct_pc;
    end
    flush_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      upd_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      upd_q         <= upd_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_resolved_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (accept && ctrl),
    .o_count (o_resolved_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (accept && mispredict),
    .o_count (o_mispredict_count)
  );

  assign o_update        = upd_q.valid;
  assign o_update_pc     = XLEN'(upd_q.pc);
  assign o_update_target = XLEN'(upd_q.target);
  assign o_update_taken  = upd_q.taken;
  assign o_redirect      = redirect_q;
  assign o_redirect_pc   = redirect_pc_q;
  assign o_flush         = flush_q;

  a_branch_jump_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_valid && i_is_branch && i_is_jump));

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver against a cycle-level outcome model.
module tb_branch_resolver;

  localparam int unsigned FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst, stall, valid, is_br, is_jmp, is_cmp, act_tk, pred_tk;
  logic [31:0] pc, act_tgt, pred_tgt;

  logic        upd, upd_tk, redir, flush;
  logic [31:0] upd_pc, upd_tgt, redir_pc, res_cnt, mis_cnt;
  logic        s_upd, s_upd_tk, s_redir, s_flush;
  logic [31:0] s_upd_pc, s_upd_tgt, s_redir_pc;
  logic [3:0]  s_res_cnt, s_mis_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle and model state.
  logic        e_upd, e_upd_tk, e_redir, e_flush;
  logic [31:0] e_upd_pc, e_upd_tgt, e_redir_pc;
  longint      e_res, e_mis, e_res4, e_mis4;
  int          blind_left;
  bit          blind_first;

  always #5 clk = ~clk;

  branch_resolver #(.XLEN(32), .FLUSH_CYCLES(FLUSH), .CNT_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_valid(valid), .i_pc(pc),
    .i_is_branch(is_br), .i_is_jump(is_jmp), .i_is_compressed(is_cmp),
    .i_actual_taken(act_tk), .i_actual_target(act_tgt),
    .i_pred_taken(pred_tk), .i_pred_target(pred_tgt),
    .o_update(upd), .o_update_pc(upd_pc), .o_update_target(upd_tgt), .o_update_taken(upd_tk),
    .o_redirect(redir), .o_redirect_pc(redir_pc), .o_flush(flush),
    .o_resolved_count(res_cnt), .o_mispredict_count(mis_cnt)
  );

  branch_resolver #(.XLEN(32), .FLUSH_CYCLES(FLUSH), .CNT_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_valid(valid), .i_pc(pc),
    .i_is_branch(is_br), .i_is_jump(is_jmp), .i_is_compressed(is_cmp),
    .i_actual_taken(act_tk), .i_actual_target(act_tgt),
    .i_pred_taken(pred_tk), .i_pred_target(pred_tgt),
    .o_update(s_upd), .o_update_pc(s_upd_pc), .o_update_target(s_upd_tgt), .o_update_taken(s_upd_tk),
    .o_redirect(s_redir), .o_redirect_pc(s_redir_pc), .o_flush(s_flush),
    .o_resolved_count(s_res_cnt), .o_mispredict_count(s_mis_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outcome model: what the next cycle's outputs must be, given this cycle's inputs.
  task automatic model_eval();
    bit ctrl, eff, mis, busy;
    logic [31:0] seq;
    e_upd = 0; e_upd_tk = 0; e_redir = 0; e_upd_pc = 0; e_upd_tgt = 0; e_redir_pc = 0;
    if (rst) begin
      blind_left = 0; blind_first = 0; e_flush = 0;
      e_res = 0; e_mis = 0; e_res4 = 0; e_mis4 = 0;
      return;
    end
    busy = (blind_left > 0);
    // The redirect cycle always elapses; later shadow cycles only elapse when EX moves.
    if (busy && (blind_first || !stall)) blind_left--;
    blind_first = 0;
    if (valid && !stall && !busy) begin
      ctrl = is_br || is_jmp;
      eff  = is_jmp || (is_br && act_tk);
      seq  = pc + (is_cmp ? 32'd2 : 32'd4);
      if (ctrl) mis = (eff != pred_tk) || (eff && act_tgt != pred_tgt);
      else      mis = pred_tk;
      if (ctrl || pred_tk) begin
        e_upd = 1; e_upd_pc = pc; e_upd_tk = eff;
        e_upd_tgt = ctrl ? act_tgt : seq;
      end
      if (mis) begin
        e_redir = 1; e_redir_pc = eff ? act_tgt : seq;
        blind_left = 1 + FLUSH; blind_first = 1;
      end
      if (ctrl) begin
        if (e_res < 64'hFFFF_FFFF) e_res++;
        if (e_res4 < 15) e_res4++;
      end
      if (mis) begin
        if (e_mis < 64'hFFFF_FFFF) e_mis++;
        if (e_mis4 < 15) e_mis4++;
      end
    end
    e_flush = (blind_left > 0);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk); #1;
    check_eq("update", 64'(upd), 64'(e_upd));
    check_eq("redirect", 64'(redir), 64'(e_redir));
    check_eq("flush", 64'(flush), 64'(e_flush));
    check_eq("resolved", 64'(res_cnt), 64'(e_res));
    check_eq("mispred", 64'(mis_cnt), 64'(e_mis));
    check_eq("sat_resolved", 64'(s_res_cnt), 64'(e_res4));
    check_eq("sat_mispred", 64'(s_mis_cnt), 64'(e_mis4));
    check_eq("sat_flush", 64'(s_flush), 64'(e_flush));
    check_eq("sat_redirect", 64'(s_redir), 64'(e_redir));
    check_eq("sat_update", 64'(s_upd), 64'(e_upd));
    if (e_upd) begin
      check_eq("update_pc", 64'(upd_pc), 64'(e_upd_pc));
      check_eq("update_target", 64'(upd_tgt), 64'(e_upd_tgt));
      check_eq("update_taken", 64'(upd_tk), 64'(e_upd_tk));
      check_eq("sat_update_target", 64'(s_upd_tgt), 64'(e_upd_tgt));
      check_eq("sat_update_taken", 64'(s_upd_tk), 64'(e_upd_tk));
      check_eq("sat_update_pc", 64'(s_upd_pc), 64'(e_upd_pc));
    end
    if (e_redir) begin
      check_eq("redirect_pc", 64'(redir_pc), 64'(e_redir_pc));
      check_eq("sat_redirect_pc", 64'(s_redir_pc), 64'(e_redir_pc));
    end
  endtask

  task automatic issue(input logic [31:0] ipc, input logic br, input logic jmp, input logic cmp,
                       input logic at, input logic [31:0] atgt, input logic pt, input logic [31:0] ptgt);
    valid = 1; stall = 0; pc = ipc; is_br = br; is_jmp = jmp; is_cmp = cmp;
    act_tk = at; act_tgt = atgt; pred_tk = pt; pred_tgt = ptgt;
    tick();
    valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; stall = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    logic [31:0] snap;
    rst = 1; stall = 0; valid = 0; pc = 0; is_br = 0; is_jmp = 0; is_cmp = 0;
    act_tk = 0; act_tgt = 0; pred_tk = 0; pred_tgt = 0;
    blind_left = 0; blind_first = 0;
    do_reset();
    check_eq("rst_flush", 64'(flush), 64'(0));
    check_eq("rst_counts", 64'(res_cnt + mis_cnt), 64'(0));

    // Correctly predicted taken branch.
    issue(32'h100, 1, 0, 0, 1, 32'h200, 1, 32'h200);
    check_eq("tp1_target", 64'(upd_tgt), 64'(32'h200));
    check_eq("tp1_noredir", 64'(redir), 64'(0));

    // Predicted not-taken, actually taken; wrong-path valid is ignored during the shadow.
    issue(32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h0);
    check_eq("tp2_redir_pc", 64'(redir_pc), 64'(32'h80));
    snap = res_cnt;
    valid = 1; pred_tk = 1;
    repeat (3) tick();
    check_eq("tp2_ignored", 64'(res_cnt), 64'(snap));
    valid = 0;
    tick();
    check_eq("tp2_flush_done", 64'(flush), 64'(0));

    // Predicted taken, actually not-taken (compressed and full-width).
    issue(32'h102, 1, 0, 1, 0, 32'h500, 1, 32'h500);
    check_eq("tp3_c_pc", 64'(redir_pc), 64'(32'h104));
    repeat (3) tick();
    issue(32'h100, 1, 0, 0, 0, 32'h500, 1, 32'h500);
    check_eq("tp3_w_pc", 64'(redir_pc), 64'(32'h104));
    repeat (3) tick();

    // JALR with a wrong predicted target.
    issue(32'h300, 0, 1, 0, 0, 32'h500, 1, 32'h400);
    check_eq("tp4_pc", 64'(redir_pc), 64'(32'h500));
    repeat (3) tick();

    // Stale BTB hit on a non-control instruction, then stall inside the shadow.
    issue(32'h40, 0, 0, 0, 0, 32'h0, 1, 32'h999);
    check_eq("tp5_tgt", 64'(upd_tgt), 64'(32'h44));
    tick();
    stall = 1;
    repeat (3) tick();
    check_eq("tp5_stall_flush", 64'(flush), 64'(1));
    stall = 0;
    repeat (3) tick();

    // Wrap-around of the sequential PC.
    issue(32'hFFFF_FFFE, 1, 0, 1, 0, 32'h10, 1, 32'h10);
    check_eq("wrap_pc", 64'(redir_pc), 64'(32'h0));
    repeat (3) tick();

    // Saturation of the 4-bit counters.
    do_reset();
    repeat (17) begin
      issue(32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h0);
      repeat (3) tick();
    end
    check_eq("sat_hold", 64'(s_mis_cnt), 64'(4'hF));

    // Reset in the middle of the shadow.
    issue(32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h0);
    tick();
    do_reset();
    check_eq("midrst_flush", 64'(flush), 64'(0));
    check_eq("midrst_mis", 64'(mis_cnt), 64'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int kind;
      rst    = ($urandom_range(0, 499) == 0);
      valid  = ($urandom_range(0, 9) < 7);
      stall  = ($urandom_range(0, 9) < 2);
      kind   = $urandom_range(0, 2);
      is_br  = (kind == 1);
      is_jmp = (kind == 2);
      is_cmp = $urandom_range(0, 1) == 1;
      pc     = ($urandom_range(0, 9) == 0) ? (is_cmp ? 32'hFFFF_FFFE : 32'hFFFF_FFFC)
                                           : ($urandom() & 32'hFFFF_FFFE);
      act_tk   = $urandom_range(0, 1) == 1;
      act_tgt  = $urandom() & 32'hFFFF_FFFE;
      pred_tk  = $urandom_range(0, 1) == 1;
      pred_tgt = ($urandom_range(0, 1) == 1) ? act_tgt : ($urandom() & 32'hFFFF_FFFE);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage counterpart to the IF-stage BTB predictor.
- Compares each control-flow instruction's predicted outcome (carried down the pipe from IF) against its actual outcome.
- Drives the BTB update interface, issues a front-end redirect on misprediction, and holds a flush shadow while wrong-path instructions drain.
- Keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, number of unstalled cycles after a redirect during which EX inputs are wrong-path and must be ignored. Legal range 1..15.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_stall  in  1  EX stage held; no resolution, shadow count frozen
- i_valid  in  1  EX holds a valid instruction
- i_pc  in  XLEN  PC of EX instruction
- i_is_branch  in  1  conditional branch
- i_is_jump  in  1  JAL/JALR (always taken)
- i_is_compressed  in  1  16-bit instruction (sequential step 2, else 4)
- i_actual_taken  in  1  branch condition result (ignored for jumps)
- i_actual_target  in  XLEN  computed target
- i_pred_taken  in  1  IF prediction carried with the instruction
- i_pred_target  in  XLEN  IF predicted target
- o_update  out  1  BTB update strobe
- o_update_pc  out  XLEN  BTB update PC
- o_update_target  out  XLEN  BTB update target
- o_update_taken  out  1  BTB update outcome
- o_redirect  out  1  one-cycle redirect pulse to IF
- o_redirect_pc  out  XLEN  correct next PC
- o_flush  out  1  kill younger instructions in IF/ID
- o_resolved_count  out  CNT_WIDTH  control-flow instructions resolved
- o_mispredict_count  out  CNT_WIDTH  mispredictions

Behaviour:
- Reset: all outputs 0, state IDLE, shadow counter 0, both perf counters 0. Reset mid-SHADOW returns to IDLE immediately.
- Accept condition: i_valid && !i_stall && state==IDLE.
- eff_taken = i_is_jump | (i_is_branch & i_actual_taken).
- seq_pc = i_pc + (i_is_compressed ? 2 : 4), modulo 2^XLEN (wraps at 0xFFFFFFFE/0xFFFFFFFC).
- ctrl = i_is_branch | i_is_jump.
- Mispredict when:
  - ctrl && eff_taken != i_pred_taken, or
  - ctrl && eff_taken && i_pred_taken && i_actual_target != i_pred_target, or
  - !ctrl && i_pred_taken (stale/aliased BTB entry).
- Correct PC = eff_taken ? i_actual_target : seq_pc.
- Latency: all outputs are registered and appear the cycle after accept, for exactly one cycle.
- Update on accept:
  - Ctrl: o_update=1, pc=i_pc, target=i_actual_target, taken=eff_taken.
  - !ctrl with i_pred_taken: update with taken=0 and target=seq_pc, to decay the entry.
  - Otherwise no update.
- o_redirect and o_redirect_pc=correct PC pulse one cycle after an accepted mispredict. The pulse is not stretched by i_stall; IF must take it.
- FSM:
  - IDLE -> REDIRECT on accepted mispredict.
  - REDIRECT (1 cycle; outputs pulse; o_flush=1) -> SHADOW, loading shadow counter = FLUSH_CYCLES.
  - SHADOW: o_flush=1; i_valid ignored. Counter decrements only when !i_stall. At 0 -> IDLE; o_flush deasserts that cycle.
  - Correctly predicted instructions stay in IDLE; back-to-back accepts are allowed every cycle.
- Perf counters:
  - o_resolved_count +1 per accepted ctrl instruction.
  - o_mispredict_count +1 per accepted mispredict, including !ctrl.
  - Both saturate at all-ones, with no wrap.
  - Updates are visible with the same latency as o_update.
- i_stall with i_valid: no accept, no outputs, no counting.
- i_is_branch && i_is_jump together is illegal; assertion only.

Decomposition:
- Shared package `branch_pkg`:
  - resolver state enum (IDLE, REDIRECT, SHADOW).
  - ILEN_STEP constants (2/4).
  - A btb_update_t struct for the update bundle, shareable with the predictor side.
- One sub-module: `sat_counter` (parameterised width, increment enable, synchronous clear, saturate at max), instantiated twice for the perf counters.

Test Plan:
- Branch at 0x100, pred_taken=1, pred_target=0x200, actual_taken=1, target 0x200 -> cycle+1: o_update=1 taken=1 target=0x200, no redirect, resolved=1, mispred=0.
- Branch at 0x100, pred_taken=0, actual taken to 0x80 -> o_redirect=1 pc=0x80, o_flush high 1+2 cycles, i_valid during shadow ignored (counters unchanged), mispred=1.
- Compressed branch at 0x102, pred_taken=1, actual not-taken -> redirect_pc=0x104, update taken=0; same with 32-bit at 0x100 -> 0x104.
- JALR at 0x300, pred_taken=1, pred_target=0x400, actual 0x500 -> redirect to 0x500, update target=0x500 taken=1.
- Non-ctrl at 0x40 with pred_taken=1 -> update taken=0 target=0x44, redirect 0x44. Then assert i_stall 3 cycles in SHADOW -> o_flush stays high 3 extra cycles.
- Preload mispredict counter near max (CNT_WIDTH=4 build, 15 mispredicts, then a 16th) -> holds at 0xF. i_rst asserted mid-SHADOW -> next cycle o_flush=0, counters 0, state IDLE.
